// File: rtl/axi_mem_tester.sv
// axi_mem_tester: AXI4 initiator that writes NUM_BURSTS INCR bursts of a known
// pattern, reads them back and checks data, response, ID and last framing.
// Reports busy/done/pass, a saturating error count and the first failing address.
// Optional macro AXI_MEM_TESTER_LFSR_EN: the data pattern comes from a 32-bit
// Galois LFSR seeded with SEED instead of the address-derived default.
module axi_mem_tester #(
  parameter int unsigned     ADDR_BITS  = 32'd32,
  parameter int unsigned     DATA_BITS  = 32'd64,
  parameter int unsigned     ID_BITS    = 32'd5,
  parameter int unsigned     BEAT_LEN   = 32'd8,
  parameter int unsigned     NUM_BURSTS = 32'd16,
  parameter longint unsigned BASE_ADDR  = 64'd0,
  parameter logic [31:0]     SEED       = 32'h0000_0001
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          err_count,
  output logic [ADDR_BITS-1:0] first_err_addr,
  output logic                 axi_aw_valid,
  input  logic                 axi_aw_ready,
  output logic [ADDR_BITS-1:0] axi_aw_addr,
  output logic [7:0]           axi_aw_len,
  output logic [2:0]           axi_aw_size,
  output logic [1:0]           axi_aw_burst,
  output logic                 axi_aw_lock,
  output logic [3:0]           axi_aw_cache,
  output logic [2:0]           axi_aw_prot,
  output logic [3:0]           axi_aw_qos,
  output logic [ID_BITS-1:0]   axi_aw_id,
  output logic                 axi_w_valid,
  input  logic                 axi_w_ready,
  output logic [DATA_BITS-1:0] axi_w_data,
  output logic                 axi_w_last,
  output logic [DATA_BITS/8-1:0] axi_w_strb,
  input  logic                 axi_b_valid,
  output logic                 axi_b_ready,
  input  logic [1:0]           axi_b_resp,
  input  logic [ID_BITS-1:0]   axi_b_id,
  output logic                 axi_ar_valid,
  input  logic                 axi_ar_ready,
  output logic [ADDR_BITS-1:0] axi_ar_addr,
  output logic [7:0]           axi_ar_len,
  output logic [2:0]           axi_ar_size,
  output logic [1:0]           axi_ar_burst,
  output logic                 axi_ar_lock,
  output logic [3:0]           axi_ar_cache,
  output logic [2:0]           axi_ar_prot,
  output logic [3:0]           axi_ar_qos,
  output logic [ID_BITS-1:0]   axi_ar_id,
  input  logic                 axi_r_valid,
  output logic                 axi_r_ready,
  input  logic [1:0]           axi_r_resp,
  input  logic [DATA_BITS-1:0] axi_r_data,
  input  logic                 axi_r_last,
  input  logic [ID_BITS-1:0]   axi_r_id
);

  localparam int unsigned BYTES = DATA_BITS / 32'd8;
  localparam int unsigned LANES = DATA_BITS / 32'd32;
  localparam int unsigned K_W   = (NUM_BURSTS > 32'd1) ? $clog2(NUM_BURSTS) : 32'd1;
  localparam logic [2:0]           SIZE        = 3'($clog2(BYTES));
  localparam logic [K_W-1:0]       LAST_K      = K_W'(NUM_BURSTS - 32'd1);
  localparam logic [7:0]           LAST_BEAT   = 8'(BEAT_LEN - 32'd1);
  localparam logic [ADDR_BITS-1:0] BEAT_BYTES  = ADDR_BITS'(BYTES);
  localparam logic [ADDR_BITS-1:0] BURST_BYTES = ADDR_BITS'(BEAT_LEN * BYTES);
  localparam logic [ADDR_BITS-1:0] BASE        = ADDR_BITS'(BASE_ADDR);

  // Reject illegal configurations at elaboration time
  if ((SEED == 32'h0) || ((DATA_BITS % 32'd32) != 32'd0) || (DATA_BITS > 32'd64) ||
      (BEAT_LEN < 32'd1) || (BEAT_LEN > 32'd256) || (NUM_BURSTS < 32'd1)) begin : g_bad_cfg
    $error("axi_mem_tester: illegal parameter set");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0, WR_AW = 3'd1, WR_W = 3'd2, WR_B = 3'd3,
    RD_AR = 3'd4, RD_R  = 3'd5, DONE = 3'd6
  } state_t;

  state_t               state_r;
  logic [K_W-1:0]       k_r;
  logic [7:0]           beat_r;
  logic [ADDR_BITS-1:0] burst_addr_r;
  logic [ADDR_BITS-1:0] beat_addr_r;

  logic                 b_hs_s, r_hs_s, r_last_beat_s, err_s;
  logic [ADDR_BITS-1:0] err_addr_s;
  logic [31:0]          first_pat_s, cur_pat_s, next_pat_s;
  logic [K_W-1:0]       next_k_s;
  logic [ADDR_BITS-1:0] next_burst_addr_s;

  // Replicate one 32-bit pattern word across every data lane
  function automatic logic [DATA_BITS-1:0] fill_lanes(input logic [31:0] lane);
    return {LANES{lane}};
  endfunction

`ifdef AXI_MEM_TESTER_LFSR_EN
  logic [31:0] lfsr_r;
  logic        seed_s, step_s;

  // One right-shifting Galois step with taps 0x8020_0003
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
  endfunction

  assign seed_s      = (((state_r == IDLE) || (state_r == DONE)) && start) ||
                       ((state_r == WR_B) && b_hs_s && (k_r == LAST_K));
  assign step_s      = (axi_w_valid && axi_w_ready) || r_hs_s;
  assign first_pat_s = lfsr_r;
  assign cur_pat_s   = lfsr_r;
  assign next_pat_s  = lfsr_step(lfsr_r);

  // Pattern generator: reseed at the start of each phase, step once per data beat
  always_ff @(posedge clock) begin
    if (reset || seed_s) lfsr_r <= SEED;
    else if (step_s)     lfsr_r <= lfsr_step(lfsr_r);
    else                 lfsr_r <= lfsr_r;
  end
`else
  // Default pattern: beat word index XOR a fixed marker, per 32-bit lane
  function automatic logic [31:0] addr_pattern(input logic [ADDR_BITS-1:0] a);
    logic [ADDR_BITS-1:0] idx;
    idx = a >> SIZE;
    return 32'(idx) ^ 32'hA5A5_A5A5;
  endfunction

  assign first_pat_s = addr_pattern(burst_addr_r);
  assign cur_pat_s   = addr_pattern(beat_addr_r);
  assign next_pat_s  = addr_pattern(beat_addr_r + BEAT_BYTES);
`endif

  // Classify the current B/R handshake and pick the address to blame
  always_comb begin
    b_hs_s            = axi_b_valid && axi_b_ready;
    r_hs_s            = axi_r_valid && axi_r_ready;
    r_last_beat_s     = (beat_r == LAST_BEAT);
    next_k_s          = k_r + K_W'(1);
    next_burst_addr_s = burst_addr_r + BURST_BYTES;
    err_s             = 1'b0;
    err_addr_s        = beat_addr_r;
    if (b_hs_s && ((axi_b_resp != 2'b00) || (axi_b_id != axi_aw_id))) begin
      err_s      = 1'b1;
      err_addr_s = burst_addr_r;
    end else if (r_hs_s && ((axi_r_data != fill_lanes(cur_pat_s)) || (axi_r_resp != 2'b00) ||
                            (axi_r_id != axi_ar_id) || (axi_r_last != r_last_beat_s))) begin
      err_s      = 1'b1;
      err_addr_s = beat_addr_r;
    end else begin
      err_s      = 1'b0;
      err_addr_s = beat_addr_r;
    end
  end

  assign axi_aw_lock  = 1'b0;
  assign axi_aw_cache = 4'h0;
  assign axi_aw_prot  = 3'h0;
  assign axi_aw_qos   = 4'h0;
  assign axi_ar_lock  = 1'b0;
  assign axi_ar_cache = 4'h0;
  assign axi_ar_prot  = 3'h0;
  assign axi_ar_qos   = 4'h0;

  // Test sequencer: one transaction at a time, all outputs registered
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;  k_r <= '0;  beat_r <= 8'd0;
      burst_addr_r <= '0;  beat_addr_r <= '0;
      busy <= 1'b0;  done <= 1'b0;  pass <= 1'b0;
      err_count <= 16'h0;  first_err_addr <= '0;
      axi_aw_valid <= 1'b0;  axi_aw_addr <= '0;  axi_aw_len <= 8'h0;
      axi_aw_size <= 3'h0;  axi_aw_burst <= 2'h0;  axi_aw_id <= '0;
      axi_w_valid <= 1'b0;  axi_w_data <= '0;  axi_w_last <= 1'b0;  axi_w_strb <= '0;
      axi_b_ready <= 1'b0;
      axi_ar_valid <= 1'b0;  axi_ar_addr <= '0;  axi_ar_len <= 8'h0;
      axi_ar_size <= 3'h0;  axi_ar_burst <= 2'h0;  axi_ar_id <= '0;
      axi_r_ready <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            state_r <= WR_AW;  busy <= 1'b1;  done <= 1'b0;  pass <= 1'b0;
            err_count <= 16'h0;  first_err_addr <= '0;
            k_r <= '0;  beat_r <= 8'd0;  burst_addr_r <= BASE;  beat_addr_r <= BASE;
            axi_aw_valid <= 1'b1;  axi_aw_addr <= BASE;  axi_aw_id <= '0;
            axi_aw_len <= LAST_BEAT;  axi_aw_size <= SIZE;  axi_aw_burst <= 2'b01;
            axi_ar_len <= LAST_BEAT;  axi_ar_size <= SIZE;  axi_ar_burst <= 2'b01;
          end
        end
        WR_AW: begin
          if (axi_aw_ready) begin
            state_r <= WR_W;  axi_aw_valid <= 1'b0;
            beat_r <= 8'd0;  beat_addr_r <= burst_addr_r;
            axi_w_valid <= 1'b1;  axi_w_data <= fill_lanes(first_pat_s);
            axi_w_last <= (LAST_BEAT == 8'd0);  axi_w_strb <= '1;
          end
        end
        WR_W: begin
          if (axi_w_ready) begin
            if (axi_w_last) begin
              state_r <= WR_B;  axi_w_valid <= 1'b0;  axi_w_last <= 1'b0;  axi_b_ready <= 1'b1;
            end else begin
              beat_r <= beat_r + 8'd1;  beat_addr_r <= beat_addr_r + BEAT_BYTES;
              axi_w_data <= fill_lanes(next_pat_s);
              axi_w_last <= (beat_r == (LAST_BEAT - 8'd1));
            end
          end
        end
        WR_B: begin
          if (b_hs_s) begin
            axi_b_ready <= 1'b0;
            if (k_r == LAST_K) begin
              state_r <= RD_AR;  k_r <= '0;  burst_addr_r <= BASE;
              axi_ar_valid <= 1'b1;  axi_ar_addr <= BASE;  axi_ar_id <= '0;
            end else begin
              state_r <= WR_AW;  k_r <= next_k_s;  burst_addr_r <= next_burst_addr_s;
              axi_aw_valid <= 1'b1;  axi_aw_addr <= next_burst_addr_s;
              axi_aw_id <= ID_BITS'(next_k_s);
            end
          end
        end
        RD_AR: begin
          if (axi_ar_ready) begin
            state_r <= RD_R;  axi_ar_valid <= 1'b0;  axi_r_ready <= 1'b1;
            beat_r <= 8'd0;  beat_addr_r <= burst_addr_r;
          end
        end
        RD_R: begin
          if (r_hs_s) begin
            if (axi_r_last || r_last_beat_s) begin
              axi_r_ready <= 1'b0;
              if (k_r == LAST_K) begin
                state_r <= DONE;  busy <= 1'b0;  done <= 1'b1;
                pass <= (err_count == 16'h0) && !err_s;
              end else begin
                state_r <= RD_AR;  k_r <= next_k_s;  burst_addr_r <= next_burst_addr_s;
                axi_ar_valid <= 1'b1;  axi_ar_addr <= next_burst_addr_s;
                axi_ar_id <= ID_BITS'(next_k_s);
              end
            end else begin
              beat_r <= beat_r + 8'd1;  beat_addr_r <= beat_addr_r + BEAT_BYTES;
            end
          end
        end
        default: state_r <= IDLE;
      endcase
      if (err_s) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'h1;
        if (err_count == 16'h0)    first_err_addr <= err_addr_s;
      end
    end
  end

endmodule

// File: tb/tb_axi_mem_tester.sv
// Self-checking bench for axi_mem_tester: a behavioural AXI memory responder with
// optional random stalls and fault injection, plus a reference model of the
// expected bursts, data pattern and error report.
module tb_axi_mem_tester;
  logic clock = 1'b0, reset, start;
  logic busy, done, pass;
  logic [15:0] err_count;
  logic [31:0] first_err_addr;
  logic aw_valid, aw_ready, aw_lock; logic [31:0] aw_addr; logic [7:0] aw_len;
  logic [2:0] aw_size, aw_prot; logic [1:0] aw_burst; logic [3:0] aw_cache, aw_qos; logic [4:0] aw_id;
  logic w_valid, w_ready, w_last; logic [63:0] w_data; logic [7:0] w_strb;
  logic b_valid, b_ready; logic [1:0] b_resp; logic [4:0] b_id;
  logic ar_valid, ar_ready, ar_lock; logic [31:0] ar_addr; logic [7:0] ar_len;
  logic [2:0] ar_size, ar_prot; logic [1:0] ar_burst; logic [3:0] ar_cache, ar_qos; logic [4:0] ar_id;
  logic r_valid, r_ready, r_last; logic [1:0] r_resp; logic [63:0] r_data; logic [4:0] r_id;

  axi_mem_tester #(.ADDR_BITS(32), .DATA_BITS(64), .ID_BITS(5), .BEAT_LEN(8),
                   .NUM_BURSTS(4), .BASE_ADDR(64'd0), .SEED(32'h1)) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .axi_aw_valid(aw_valid), .axi_aw_ready(aw_ready), .axi_aw_addr(aw_addr), .axi_aw_len(aw_len),
    .axi_aw_size(aw_size), .axi_aw_burst(aw_burst), .axi_aw_lock(aw_lock), .axi_aw_cache(aw_cache),
    .axi_aw_prot(aw_prot), .axi_aw_qos(aw_qos), .axi_aw_id(aw_id),
    .axi_w_valid(w_valid), .axi_w_ready(w_ready), .axi_w_data(w_data), .axi_w_last(w_last),
    .axi_w_strb(w_strb), .axi_b_valid(b_valid), .axi_b_ready(b_ready), .axi_b_resp(b_resp),
    .axi_b_id(b_id), .axi_ar_valid(ar_valid), .axi_ar_ready(ar_ready), .axi_ar_addr(ar_addr),
    .axi_ar_len(ar_len), .axi_ar_size(ar_size), .axi_ar_burst(ar_burst), .axi_ar_lock(ar_lock),
    .axi_ar_cache(ar_cache), .axi_ar_prot(ar_prot), .axi_ar_qos(ar_qos), .axi_ar_id(ar_id),
    .axi_r_valid(r_valid), .axi_r_ready(r_ready), .axi_r_resp(r_resp), .axi_r_data(r_data),
    .axi_r_last(r_last), .axi_r_id(r_id));

  always #5 clock = ~clock;

  int checks = 0, passes = 0, proto_err = 0;
  bit stall_en = 0;
  int corrupt_addr = -1, bad_b_burst = -1;
  logic [63:0] mem [0:31];
  logic [63:0] wlog[$];
  logic        wlast_log[$];
  logic [31:0] awlog[$], arlog[$], fault_q[$];
  logic [4:0]  awid_log[$], arid_log[$];
  logic [12:0] awfld_log[$];
  logic [14:0] awzero_log[$];
  logic [31:0] lfsr_seq [0:31];

  // Responder-side state
  int w_base, w_cnt, r_base, r_cnt, r_len;
  bit b_pend, b_hs, r_act, r_hs, aw_wait, w_wait, ar_wait;
  logic [4:0] b_id_q, r_id_q;
  logic [49:0] aw_snap, ar_snap;
  logic [72:0] w_snap;

  function automatic bit rnd();
    return !stall_en || ($urandom_range(1, 0) == 1);
  endfunction

  // Reference pattern for global beat n of a phase (beat byte address n*8)
  function automatic logic [63:0] exp_beat(input int n);
`ifdef AXI_MEM_TESTER_LFSR_EN
    return {lfsr_seq[n], lfsr_seq[n]};
`else
    logic [31:0] lane;
    lane = 32'((n * 8) / 8) ^ 32'hA5A5_A5A5;
    return {lane, lane};
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock); #2;
  endtask

  // AXI memory responder, driven on the falling edge
  initial begin
    aw_ready = 0; w_ready = 0; ar_ready = 0; b_valid = 0; b_resp = 0; b_id = 0;
    r_valid = 0; r_resp = 0; r_data = 0; r_last = 0; r_id = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        aw_ready = 0; w_ready = 0; ar_ready = 0; b_valid = 0; r_valid = 0; r_last = 0;
        b_pend = 0; b_hs = 0; r_act = 0; r_hs = 0; aw_wait = 0; w_wait = 0; ar_wait = 0;
      end else begin
        if (aw_wait && (!aw_valid || aw_snap != {aw_addr, aw_len, aw_size, aw_burst, aw_id})) proto_err++;
        if (w_wait && (!w_valid || w_snap != {w_data, w_last, w_strb})) proto_err++;
        if (ar_wait && (!ar_valid || ar_snap != {ar_addr, ar_len, ar_size, ar_burst, ar_id})) proto_err++;
        if (b_hs) begin b_valid = 0; b_hs = 0; end
        if (r_hs) begin
          r_valid = 0; r_hs = 0; r_cnt++;
          if (r_cnt == r_len) r_act = 0;
        end
        if (b_pend && !b_valid && rnd()) begin
          b_valid = 1; b_pend = 0; b_id = b_id_q;
          b_resp = ((w_base / 64) == bad_b_burst) ? 2'b10 : 2'b00;
          if (b_resp != 2'b00) fault_q.push_back(32'(w_base));
        end
        b_hs = b_valid && b_ready;
        aw_ready = rnd();
        if (aw_valid && aw_ready) begin
          awlog.push_back(aw_addr); awid_log.push_back(aw_id);
          awfld_log.push_back({aw_len, aw_size, aw_burst});
          awzero_log.push_back({aw_lock, aw_cache, aw_prot, aw_qos, 3'b000});
          w_base = int'(aw_addr); w_cnt = 0; b_id_q = aw_id;
        end
        aw_wait = aw_valid && !aw_ready; aw_snap = {aw_addr, aw_len, aw_size, aw_burst, aw_id};
        w_ready = rnd();
        if (w_valid && w_ready) begin
          mem[(w_base / 8 + w_cnt) % 32] = w_data;
          wlog.push_back(w_data); wlast_log.push_back(w_last); w_cnt++;
          if (w_last) b_pend = 1;
        end
        w_wait = w_valid && !w_ready; w_snap = {w_data, w_last, w_strb};
        if (r_act && !r_valid && rnd()) begin
          r_valid = 1; r_id = r_id_q; r_resp = 0; r_last = (r_cnt == r_len - 1);
          r_data = mem[(r_base / 8 + r_cnt) % 32];
          if (r_base + r_cnt * 8 == corrupt_addr) begin
            r_data[0] = ~r_data[0];
            fault_q.push_back(32'(r_base + r_cnt * 8));
          end
        end
        r_hs = r_valid && r_ready;
        ar_ready = rnd();
        if (ar_valid && ar_ready) begin
          arlog.push_back(ar_addr); arid_log.push_back(ar_id);
          r_base = int'(ar_addr); r_cnt = 0; r_len = int'(ar_len) + 1; r_id_q = ar_id; r_act = 1;
        end
        ar_wait = ar_valid && !ar_ready; ar_snap = {ar_addr, ar_len, ar_size, ar_burst, ar_id};
      end
    end
  end

  task automatic clear_logs();
    wlog.delete(); wlast_log.delete(); awlog.delete(); arlog.delete(); fault_q.delete();
    awid_log.delete(); arid_log.delete(); awfld_log.delete(); awzero_log.delete();
  endtask

  // Full test run against the reference model of bursts, data and error report
  task automatic run_test(input string tag, input bit st, input int corr, input int badb);
    logic [31:0] lasts;
    logic [31:0] exp_first;
    stall_en = st; corrupt_addr = corr; bad_b_burst = badb; proto_err = 0;
    clear_logs();
    start = 1; tick(); start = 0;
    check({tag, "_aw_valid_after_start"}, 64'(aw_valid), 64'd1);
    for (int i = 0; i < 4000 && !done; i++) tick();
    check({tag, "_done"}, 64'({done, busy}), 64'b10);
    exp_first = (fault_q.size() > 0) ? fault_q[0] : 32'h0;
    check({tag, "_err_count"}, 64'(err_count), 64'(fault_q.size()));
    check({tag, "_first_err_addr"}, 64'(first_err_addr), 64'(exp_first));
    check({tag, "_pass"}, 64'(pass), 64'(fault_q.size() == 0));
    check({tag, "_stable_payload"}, 64'(proto_err), 64'd0);
    check({tag, "_w_beats"}, 64'(wlog.size()), 64'd32);
    lasts = 32'h0;
    for (int n = 0; n < wlog.size() && n < 32; n++) begin
      if (wlast_log[n]) lasts[n] = 1'b1;
      if (wlog[n] !== exp_beat(n)) check({tag, "_w_data"}, wlog[n], exp_beat(n));
    end
    check({tag, "_w_last_map"}, 64'(lasts), 64'h8080_8080);
    check({tag, "_bursts"}, 64'({awlog.size(), arlog.size()}), {32'd4, 32'd4});
    for (int k = 0; k < awlog.size() && k < 4; k++) begin
      check({tag, "_aw_addr_id"}, {27'd0, awid_log[k], awlog[k]}, {27'd0, 5'(k), 32'(k * 64)});
      check({tag, "_aw_fields"}, 64'({awfld_log[k], awzero_log[k]}), 64'({8'd7, 3'd3, 2'd1, 15'd0}));
    end
    for (int k = 0; k < arlog.size() && k < 4; k++)
      check({tag, "_ar_addr_id"}, {27'd0, arid_log[k], arlog[k]}, {27'd0, 5'(k), 32'(k * 64)});
  endtask

  initial begin
    logic [31:0] v;
    reset = 1; start = 0;
    v = 32'h1;
    for (int i = 0; i < 32; i++) begin
      lfsr_seq[i] = v;
      v = v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
    end
    repeat (3) tick();
    reset = 0; tick();
    check("reset_ctrl", 64'({aw_valid, w_valid, b_ready, ar_valid, r_ready, busy, done, pass}), 64'd0);
    check("reset_err", {err_count, first_err_addr}, 64'd0);
    check("reset_payload", {aw_addr, aw_len, aw_size, aw_burst, aw_id, w_strb, w_last}, 64'd0);

    // Directed clean run, then the spec's concrete beat values
    run_test("clean", 0, -1, -1);
`ifdef AXI_MEM_TESTER_LFSR_EN
    check("lfsr_beat0", wlog[0], 64'h0000_0001_0000_0001);
    check("lfsr_beat1", wlog[1], 64'h8020_0003_8020_0003);
`else
    check("addr_beat1", wlog[1], 64'hA5A5_A5A4_A5A5_A5A4);
`endif

    run_test("corrupt48", 0, 32'h48, -1);
    run_test("bresp1", 0, -1, 1);
    run_test("stall_a", 1, -1, -1);
    run_test("stall_b", 1, -1, -1);
    run_test("stall_corrupt", 1, int'($urandom_range(31, 0)) * 8, -1);
    run_test("stall_bresp", 1, -1, int'($urandom_range(3, 0)));
    run_test("stall_both", 1, int'($urandom_range(31, 0)) * 8, int'($urandom_range(3, 0)));

    // Reset after W beat 3 of burst 0, then a full clean run
    stall_en = 0; corrupt_addr = 32'h48; bad_b_burst = -1; clear_logs();
    start = 1; tick(); start = 0;
    for (int i = 0; i < 200 && wlog.size() < 4; i++) tick();
    check("rst_reach_beat3", 64'(wlog.size()), 64'd4);
    reset = 1; tick();
    check("rst_mid_ctrl", 64'({aw_valid, w_valid, b_ready, ar_valid, r_ready, busy, done}), 64'd0);
    check("rst_mid_err", 64'(err_count), 64'd0);
    reset = 0; tick();
    run_test("after_reset", 0, -1, -1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
